// File: rtl/cdc_tx_sched.sv
// Source-domain scheduler sharing one mux/N-FF synchronizer path among NREQ requesters.
// Round-robin arbitration, en held HOLD_CYCLES then low for GAP_CYCLES; data held until next accept.
module cdc_tx_sched #(
   parameter int NREQ        = 4,
   parameter int DW          = 8,
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                      clka,
   input  logic                      rstn,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DW-1:0]        req_data,
   output logic [NREQ-1:0]           req_ready,
   output logic [DW-1:0]             data,
   output logic                      en,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      busy,
   output logic                      done
);

   localparam int IW   = $clog2(NREQ);
   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [IW-1:0]   rr_ptr, rr_ptr_nx;
   logic [IW-1:0]   win, idx;
   logic            found;
   logic [DW-1:0]   data_nx;
   logic            en_nx, busy_nx, done_nx;
   logic [IW-1:0]   gid_nx;

   // First valid requester scanning upward from rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IW'((32'(rr_ptr) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found)
         req_ready[win] = 1'b1;
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      rr_ptr_nx = rr_ptr;
      data_nx   = data;
      en_nx     = en;
      gid_nx    = grant_id;
      busy_nx   = busy;
      done_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (found && req_valid[win] && req_ready[win]) begin
               data_nx   = req_data[int'(win)*DW +: DW];
               en_nx     = 1'b1;
               gid_nx    = win;
               busy_nx   = 1'b1;
               cnt_nx    = CW'(HOLD_CYCLES - 1);
               rr_ptr_nx = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
               state_nx  = HOLD;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               en_nx    = 1'b0;
               cnt_nx   = CW'(GAP_CYCLES - 1);
               state_nx = GAP;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= '0;
         rr_ptr   <= '0;
         data     <= '0;
         en       <= 1'b0;
         grant_id <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         rr_ptr   <= rr_ptr_nx;
         data     <= data_nx;
         en       <= en_nx;
         grant_id <= gid_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

endmodule

// File: tb/tb_cdc_tx_sched.sv
// Bench for cdc_tx_sched: timeline reference model, arbitration table, directed corners, random traffic.
// A clkb-domain 2-FF sampler stands in for the downstream synchronizer.
module tb_cdc_tx_sched;

   localparam int N = 4;
   localparam int W = 8;
   localparam int H = 8;
   localparam int G = 4;

   logic          clka, clkb, rstn;
   logic [N-1:0]  rv;
   logic [N*W-1:0] rd;
   logic [N-1:0]  rdy;
   logic [W-1:0]  data;
   logic          en, busy, done;
   logic [1:0]    gid;

   cdc_tx_sched #(.NREQ(N), .DW(W), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
      .clka(clka), .rstn(rstn), .req_valid(rv), .req_data(rd), .req_ready(rdy),
      .data(data), .en(en), .grant_id(gid), .busy(busy), .done(done)
   );

   initial begin clka = 0; forever #5 clka = ~clka; end
   initial begin clkb = 0; #7; forever #15 clkb = ~clkb; end

   // downstream sampler: synchronize en, capture data on its synchronized rising edge
   logic s1 = 0, s2 = 0, s3 = 0;
   logic [W-1:0] rx_q[$];
   always @(posedge clkb) begin
      s1 <= en; s2 <= s1; s3 <= s2;
      if (s2 && !s3) rx_q.push_back(data);
   end

   int n_chk = 0, n_err = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference: outputs follow from cycles elapsed since the last accept.
   int          m_since, m_ptr, m_gid;
   logic [W-1:0] m_data;

   function automatic int m_winner(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   int cyc_n = 0, low_run = 0, en_hi = 0, done_cnt = 0, gap_cnt = 0;
   logic prev_en = 0;
   int rise_cyc[$], rise_gid[$], rise_data[$], low_runs[$];

   task automatic clear_stats();
      rise_cyc.delete(); rise_gid.delete(); rise_data.delete(); low_runs.delete();
      en_hi = 0; done_cnt = 0; gap_cnt = 0;
   endtask

   task automatic cyc();
      int w;
      logic [N-1:0] exp_rdy;
      #2;
      w = m_winner(rv);
      exp_rdy = (m_since >= H + G && w >= 0) ? 4'(1 << w) : 4'b0;
      chk("req_ready", 32'(rdy), 32'(exp_rdy));
      @(posedge clka);
      w = m_winner(rv);
      if (m_since >= H + G && w >= 0) begin
         m_since = 0; m_data = rd[w*W +: W]; m_gid = w; m_ptr = (w + 1) % N;
      end else if (m_since <= H + G) begin
         m_since++;
      end
      #1;
      chk("en",       32'(en),   32'(m_since < H));
      chk("busy",     32'(busy), 32'(m_since < H + G));
      chk("done",     32'(done), 32'(m_since == H + G));
      chk("data",     32'(data), 32'(m_data));
      chk("grant_id", 32'(gid),  32'(m_gid));
      cyc_n++;
      if (en && !prev_en) begin
         rise_cyc.push_back(cyc_n); rise_gid.push_back(int'(gid));
         rise_data.push_back(int'(data)); low_runs.push_back(low_run);
      end
      low_run = en ? 0 : low_run + 1;
      prev_en = en;
      en_hi += int'(en); done_cnt += int'(done); gap_cnt += int'(busy && !en);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wait_rises(input string nm, input int target, input int budget);
      int b = 0;
      while (rise_cyc.size() < target && b < budget) begin cyc(); b++; end
      chk({nm, "_rises"}, 32'(rise_cyc.size()), 32'(target));
   endtask

   // entered at posedge+1; asynchronous effect checked before the next edge
   task automatic do_reset();
      rstn = 0;
      #1;
      chk("rst_en",   32'(en),   0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_data", 32'(data), 0);
      chk("rst_gid",  32'(gid),  0);
      m_since = H + G + 1; m_ptr = 0; m_gid = 0; m_data = '0; prev_en = 0;
      @(posedge clka); #1;
      rstn = 1;
   endtask

   typedef struct { logic [N-1:0] v; logic [N-1:0] rdy; } arb_vec_t;
   arb_vec_t tbl[6];
   int exp_rr[5];

   initial begin
      tbl[0] = '{4'b0001, 4'b0001};
      tbl[1] = '{4'b0110, 4'b0010};
      tbl[2] = '{4'b1000, 4'b1000};
      tbl[3] = '{4'b0000, 4'b0000};
      tbl[4] = '{4'b1111, 4'b0001};
      tbl[5] = '{4'b1100, 4'b0100};
      exp_rr = '{0, 1, 2, 3, 0};

      rstn = 0; rv = '0; rd = '0;
      @(posedge clka); #1;
      do_reset();

      // combinational arbitration at rr_ptr=0, all within one cycle
      foreach (tbl[i]) begin
         rv = tbl[i].v; #1;
         chk($sformatf("arb_tbl%0d", i), 32'(rdy), 32'(tbl[i].rdy));
      end
      rv = '0;
      @(posedge clka); #1;
      run(1);

      // single transfer from requester 1
      clear_stats(); rx_q.delete();
      rv = 4'b0010; rd = 32'h0000_5500;
      #1; chk("single_ready", 32'(rdy), 32'h2);
      cyc();
      rv = '0; rd = '0;
      run(20);
      chk("single_en_hi", 32'(en_hi), H);
      chk("single_gap",   32'(gap_cnt), G);
      chk("single_done",  32'(done_cnt), 1);
      chk("single_gid",   32'(gid), 1);
      chk("single_rx_n",  32'(rx_q.size()), 1);
      if (rx_q.size() > 0) chk("single_rx", 32'(rx_q[0]), 32'h55);

      // back-to-back from requester 0
      clear_stats(); rx_q.delete();
      rv = 4'b0001; rd = 32'h0000_0055;
      begin
         int b = 0;
         while (rise_cyc.size() < 2 && b < 40) begin
            cyc(); b++;
            if (rise_cyc.size() >= 1) rd[7:0] = 8'hFF;
         end
      end
      rv = '0;
      chk("b2b_rises", 32'(rise_cyc.size()), 2);
      run(20);
      if (rise_cyc.size() >= 2) begin
         chk("b2b_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 13);
         chk("b2b_lowrun",  32'(low_runs[1]), 5);
      end
      chk("b2b_rx_n", 32'(rx_q.size()), 2);
      if (rx_q.size() >= 2) begin
         chk("b2b_rx0", 32'(rx_q[0]), 32'h55);
         chk("b2b_rx1", 32'(rx_q[1]), 32'hFF);
      end

      // round robin with all four requesting
      do_reset();
      clear_stats();
      rv = 4'b1111; rd = 32'hA3A2_A1A0;
      wait_rises("rr", 5, 80);
      rv = '0;
      for (int i = 0; i < 5 && i < rise_gid.size(); i++) begin
         chk($sformatf("rr_gid%0d", i),  32'(rise_gid[i]),  32'(exp_rr[i]));
         chk($sformatf("rr_data%0d", i), 32'(rise_data[i]), 32'hA0 + 32'(exp_rr[i]));
      end
      run(14);

      // pointer at 3, only requester 1 valid, then all valid -> grant 2
      do_reset();
      clear_stats();
      rv = 4'b0100; rd = 32'h0044_0000;
      wait_rises("wrap_a", 1, 5);
      rv = '0; run(14);
      clear_stats();
      rv = 4'b0010; rd = 32'h0000_1100;
      wait_rises("wrap_b", 1, 5);
      if (rise_gid.size() > 0) chk("wrap_gid1", 32'(rise_gid[0]), 1);
      clear_stats();
      rv = 4'b1111; rd = 32'h3322_1100;
      wait_rises("wrap_c", 1, 20);
      if (rise_gid.size() > 0) chk("wrap_gid2", 32'(rise_gid[0]), 2);
      rv = '0; run(14);

      // valid raised during HOLD and withdrawn before IDLE
      clear_stats();
      rv = 4'b0001; rd = 32'h7700_003C;
      wait_rises("wd", 1, 20);
      rv = 4'b1000;
      for (int i = 0; i < 8; i++) begin
         cyc(); #1;
         chk("wd_ready", 32'(rdy), 0);
      end
      rv = '0;
      run(20);
      chk("wd_rises", 32'(rise_cyc.size()), 1);
      chk("wd_data",  32'(data), 32'h3C);

      // reset in the middle of HOLD
      clear_stats();
      rv = 4'b0100; rd = 32'h0099_0000;
      wait_rises("rst_mid", 1, 20);
      run(3);
      chk("rst_mid_en_before", 32'(en), 1);
      rv = '0;
      do_reset();
      clear_stats();
      rv = 4'b1111; rd = 32'h1234_5678;
      wait_rises("rst_after", 1, 5);
      if (rise_gid.size() > 0) chk("rst_after_gid", 32'(rise_gid[0]), 0);
      rv = '0; run(14);

      // random traffic against the reference model
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) rv = 4'($urandom);
         if ($urandom_range(0, 2) == 0) rd = $urandom;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
